// File: rtl/lcd_frame_refresh.sv
// -----------------------------------------------------------------------------
// lcd_frame_refresh
//
// Purpose
//   Keeps a 2x16 character LCD in step with a 32-entry host frame buffer.
//   The host writes characters at any time. The block repeatedly walks the
//   buffer in index order and sends one byte request per selected index to a
//   downstream byte-send block. Between frames it waits REFRESH_GAP cycles.
//
// Optional feature (compile-time macro LCD_DIRTY_SKIP_EN)
//   When defined, each index carries a dirty bit. Only dirty indices are
//   sent, so an unchanged display costs one scan and no bus traffic. When
//   undefined, every index is sent in every frame.
//
// Parameters
//   REFRESH_GAP  idle cycles between the end of one frame and the next (1..65535)
//
// Ports
//   clk_i        clock, all logic on the rising edge
//   reset_i      synchronous active-high reset
//   powerUp_i    LCD init sequence owns the bus; no new requests while high
//   wrEn_i       host write strobe (one character per cycle)
//   wrAds_i      host character index, bit 4 = row, bits 3:0 = column
//   wrData_i     host character code
//   rq_o         byte request to the byte-send block
//   ack_i        one-cycle completion pulse from the byte-send block
//   ads_o        DD RAM address of the current request
//   char_o       character of the current request
//   busy_o       high while scanning or requesting
//   frameDone_o  one-cycle pulse at the end of each frame
// -----------------------------------------------------------------------------
module lcd_frame_refresh #(
    parameter int unsigned REFRESH_GAP = 1000
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       powerUp_i,
    input  logic       wrEn_i,
    input  logic [4:0] wrAds_i,
    input  logic [7:0] wrData_i,
    output logic       rq_o,
    input  logic       ack_i,
    output logic [6:0] ads_o,
    output logic [7:0] char_o,
    output logic       busy_o,
    output logic       frameDone_o
);

    localparam int unsigned NUM_CHARS = 32;
    localparam logic [4:0]  LAST_IDX  = 5'd31;
    // The gap counter runs 0..REFRESH_GAP-1, so the GAP state lasts exactly
    // REFRESH_GAP cycles.
    localparam logic [15:0] GAP_LAST  = 16'(REFRESH_GAP - 1);
    localparam logic [7:0]  SPACE     = 8'h20;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        REQ  = 2'd2,
        GAP  = 2'd3
    } state_t;

    state_t      state_reg;
    logic [4:0]  idx_reg;
    logic [15:0] gap_cnt_reg;
    logic        rq_reg;
    logic        busy_reg;
    logic        done_reg;
    logic        pu_pend_reg;     // powerUp_i seen while a request was in flight
    logic [6:0]  ads_reg;
    logic [7:0]  char_reg;

    logic [7:0]  buf_reg [NUM_CHARS];
    logic [31:0] wr_hit;          // one-hot host write decode
    logic        sel;             // current idx is to be sent this frame

    // -------------------------------------------------------------------------
    // Host write decode
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_CHARS; gi++) begin : g_wr_dec
            assign wr_hit[gi] = wrEn_i && (wrAds_i == 5'(gi));
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Frame buffer. Kept in flops rather than block RAM because every entry
    // has to come out of reset as a space character.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NUM_CHARS; i++) begin
            if (reset_i) begin
                buf_reg[i] <= SPACE;
            end else if (wr_hit[i]) begin
                buf_reg[i] <= wrData_i;
            end
        end
    end

`ifdef LCD_DIRTY_SKIP_EN
    // -------------------------------------------------------------------------
    // Dirty tracking. A host write wins over the clear that happens when the
    // index is latched in the same cycle: the latched character is the old
    // one, so the new one still has to go out in a later frame.
    // -------------------------------------------------------------------------
    logic [31:0] dirty_reg;
    logic        latch_now;

    assign latch_now = (state_reg == SCAN) && !powerUp_i && dirty_reg[idx_reg];
    assign sel       = dirty_reg[idx_reg];

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NUM_CHARS; i++) begin
            if (reset_i) begin
                dirty_reg[i] <= 1'b1;
            end else if (wr_hit[i]) begin
                dirty_reg[i] <= 1'b1;
            end else if (latch_now && (idx_reg == 5'(i))) begin
                dirty_reg[i] <= 1'b0;
            end
        end
    end
`else
    assign sel = 1'b1;
`endif

    // -------------------------------------------------------------------------
    // Refresh sequencer. All outputs are registered and updated together with
    // the state so that busy_o and rq_o never glitch.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_reg   <= IDLE;
            idx_reg     <= 5'd0;
            gap_cnt_reg <= 16'd0;
            rq_reg      <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            pu_pend_reg <= 1'b0;
            ads_reg     <= 7'd0;
            char_reg    <= 8'd0;
        end else begin
            done_reg <= 1'b0;

            case (state_reg)
                IDLE: begin
                    idx_reg     <= 5'd0;
                    gap_cnt_reg <= 16'd0;
                    if (!powerUp_i) begin
                        state_reg <= SCAN;
                        busy_reg  <= 1'b1;
                    end
                end

                SCAN: begin
                    if (powerUp_i) begin
                        // Init sequence takes the bus: abandon the frame quietly.
                        state_reg <= IDLE;
                        idx_reg   <= 5'd0;
                        busy_reg  <= 1'b0;
                    end else if (sel) begin
                        // Buffer read sees the value before any same-cycle write.
                        state_reg   <= REQ;
                        rq_reg      <= 1'b1;
                        ads_reg     <= {idx_reg[4], 2'b00, idx_reg[3:0]};
                        char_reg    <= buf_reg[idx_reg];
                        pu_pend_reg <= 1'b0;
                    end else if (idx_reg != LAST_IDX) begin
                        idx_reg <= idx_reg + 5'd1;
                    end else begin
                        state_reg   <= GAP;
                        busy_reg    <= 1'b0;
                        done_reg    <= 1'b1;
                        gap_cnt_reg <= 16'd0;
                    end
                end

                REQ: begin
                    // ads_reg / char_reg are untouched here, so they stay
                    // stable for the whole request regardless of host writes.
                    if (ack_i) begin
                        rq_reg <= 1'b0;
                        if (pu_pend_reg || powerUp_i) begin
                            state_reg <= IDLE;
                            idx_reg   <= 5'd0;
                            busy_reg  <= 1'b0;
                        end else if (idx_reg != LAST_IDX) begin
                            // Returning through SCAN guarantees at least one
                            // low cycle on rq_o before the next request.
                            state_reg <= SCAN;
                            idx_reg   <= idx_reg + 5'd1;
                        end else begin
                            state_reg   <= GAP;
                            busy_reg    <= 1'b0;
                            done_reg    <= 1'b1;
                            gap_cnt_reg <= 16'd0;
                        end
                    end else if (powerUp_i) begin
                        pu_pend_reg <= 1'b1;
                    end
                end

                GAP: begin
                    if (powerUp_i) begin
                        state_reg   <= IDLE;
                        idx_reg     <= 5'd0;
                        gap_cnt_reg <= 16'd0;
                    end else if (gap_cnt_reg == GAP_LAST) begin
                        state_reg   <= SCAN;
                        idx_reg     <= 5'd0;
                        gap_cnt_reg <= 16'd0;
                        busy_reg    <= 1'b1;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg + 16'd1;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                    idx_reg   <= 5'd0;
                    rq_reg    <= 1'b0;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign rq_o        = rq_reg;
    assign ads_o       = ads_reg;
    assign char_o      = char_reg;
    assign busy_o      = busy_reg;
    assign frameDone_o = done_reg;

endmodule
